// File: rtl/sub_arb_pkg.sv
// Shared types and helpers for the subtractor-sharing arbiter.
// State encoding of the request/compute/hold sequence lives here.
package sub_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        HOLD    = 2'd2
    } sub_state_e;

    // Index width that stays legal for a single requester.
    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or above ptr, with wrap.
// The pointer register belongs to the parent so it only advances on an actual accept.
module rr_arbiter
    import sub_arb_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int IDW     = id_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDW-1:0]     ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDW-1:0]     gnt_idx,
    output logic               any
);

    always_comb begin : search
        int idx;
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        idx     = 0;
        for (int off = 0; off < NUM_REQ; off++) begin
            idx = (int'(ptr) + off) % NUM_REQ;
            if (!any && req[idx]) begin
                any          = 1'b1;
                gnt[idx]     = 1'b1;
                gnt_idx      = IDW'(idx);
            end
        end
    end

endmodule

// File: rtl/sub_share_arbiter.sv
// One registered subtractor shared round-robin among NUM_REQ requesters, valid/ready result.
// Optional macro SUB_SAT_EN: clamp the difference to zero whenever a borrow occurs.
module sub_share_arbiter
    import sub_arb_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    parameter  int WIDTH   = 4,
    localparam int IDW     = id_w(NUM_REQ)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*WIDTH-1:0]   req_a,
    input  logic [NUM_REQ*WIDTH-1:0]   req_b,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [IDW-1:0]             rsp_id,
    output logic [WIDTH-1:0]           rsp_diff,
    output logic                       rsp_borrow,
    output logic                       busy,
    output sub_state_e                 dbg_state
);

    // Handshakes: a requester holds req_valid and operands until its req_ready bit
    // pulses (accept on that edge); a result is consumed on an edge with
    // rsp_valid && rsp_ready, and rsp_* stay stable until then.

    sub_state_e           state;
    logic [IDW-1:0]       rr_ptr;
    logic [IDW-1:0]       op_id;
    logic [WIDTH-1:0]     op_a;
    logic [WIDTH-1:0]     op_b;
    logic [NUM_REQ-1:0]   gnt;
    logic [IDW-1:0]       gnt_idx;
    logic                 any;
    logic [WIDTH:0]       sub_ext;
    logic                 sub_borrow;
    logic [WIDTH-1:0]     sub_diff;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .req     (req_valid),
        .ptr     (rr_ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .any     (any)
    );

    // Masking with rst_n keeps the strobe low while reset is asserted.
    assign req_ready = (state == IDLE && rst_n) ? gnt : '0;
    assign busy      = (state != IDLE);
    assign dbg_state = state;

    // Leading 1 acts as the WIDTH+1 bit; it survives only when a >= b.
    assign sub_ext    = {1'b1, op_a} - {1'b0, op_b};
    assign sub_borrow = ~sub_ext[WIDTH];
`ifdef SUB_SAT_EN
    assign sub_diff   = sub_borrow ? '0 : sub_ext[WIDTH-1:0];
`else
    assign sub_diff   = sub_ext[WIDTH-1:0];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            op_id      <= '0;
            op_a       <= '0;
            op_b       <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_diff   <= '0;
            rsp_borrow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any) begin
                        op_a   <= req_a[gnt_idx*WIDTH +: WIDTH];
                        op_b   <= req_b[gnt_idx*WIDTH +: WIDTH];
                        op_id  <= gnt_idx;
                        rr_ptr <= (gnt_idx == IDW'(NUM_REQ - 1)) ? '0 : gnt_idx + IDW'(1);
                        state  <= COMPUTE;
                    end
                end
                COMPUTE: begin
                    rsp_diff   <= sub_diff;
                    rsp_borrow <= sub_borrow;
                    rsp_id     <= op_id;
                    rsp_valid  <= 1'b1;
                    state      <= HOLD;
                end
                HOLD: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
